// File: rtl/c_rr_arbiter_select_v5_0.sv
// c_rr_arbiter_select_v5_0: registered round-robin arbiter with a VALID/READY grant handshake.
// SEL/VALID drive a binary decoder's S/EN inputs; LAST is the round-robin pointer.
// Optional feature: define RR_ARB_LOCK_EN to add the LOCK port (burst hold on acceptance).
module c_rr_arbiter_select_v5_0 #(
    parameter int unsigned C_REQ_WIDTH = 8,
    parameter int unsigned C_SEL_WIDTH = 3,
    parameter int unsigned C_HAS_CE    = 0
) (
    input  logic                   CLK,
    input  logic                   SCLR_N,
    input  logic                   CE,
    input  logic [C_REQ_WIDTH-1:0] REQ,
    input  logic                   READY,
`ifdef RR_ARB_LOCK_EN
    input  logic                   LOCK,
`endif
    output logic [C_SEL_WIDTH-1:0] SEL,
    output logic                   VALID,
    output logic [C_SEL_WIDTH-1:0] LAST
);

    localparam int unsigned REQ_W = C_REQ_WIDTH;
    localparam int unsigned SEL_W = C_SEL_WIDTH;
    localparam int unsigned IDX_W = (REQ_W > 1) ? $clog2(REQ_W) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] last_q;
    logic [SEL_W-1:0] last_d;
    logic             valid_q;
    logic             valid_d;
    logic [SEL_W-1:0] search_base;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             req_any;
    logic             ce_eff;
    logic             accept;
    logic             lock_hold;

    // First set request strictly after base, wrapping; base itself is the last candidate.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [REQ_W-1:0] req,
        input logic [SEL_W-1:0] base
    );
        logic             found;
        logic [SEL_W-1:0] idx;
        int unsigned      pos;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= REQ_W; off++) begin
            pos = 32'(base) + off;
            if (pos >= REQ_W) begin
                pos = pos - REQ_W;
            end
            if (!found && req[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = SEL_W'(pos);
            end
        end
        return {found, idx};
    endfunction

    assign ce_eff  = (C_HAS_CE != 0) ? CE : 1'b1;
    assign req_any = |REQ;
    assign accept  = valid_q & READY;

    // In IDLE search after the pointer; on acceptance search after the accepted index,
    // which becomes the new pointer and is only re-picked when it is the sole requester.
    assign search_base = (state_q == ST_IDLE) ? last_q : sel_q;
    assign {pick_found, pick_idx} = rr_pick(REQ, search_base);

`ifdef RR_ARB_LOCK_EN
    // Burst hold only while the locked requester is still asking.
    assign lock_hold = LOCK & REQ[IDX_W'(sel_q)];
`else
    assign lock_hold = 1'b0;
`endif

    // State and output registers; reset wins over clock enable.
    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= SEL_W'(REQ_W - 1);
        end else if (ce_eff) begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Next-state: leave IDLE on any request, return when an acceptance finds nothing left.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept && !lock_hold && !pick_found) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next output values: register a new winner, hold under backpressure or lock.
    always_comb begin
        sel_d   = sel_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = req_any;
                sel_d   = req_any ? pick_idx : sel_q;
            end
            ST_GRANT: begin
                valid_d = 1'b1;
                if (accept && !lock_hold) begin
                    last_d  = sel_q;
                    valid_d = pick_found;
                    sel_d   = pick_found ? pick_idx : sel_q;
                end
            end
            default: valid_d = 1'b0;
        endcase
    end

    assign SEL   = sel_q;
    assign VALID = valid_q;
    assign LAST  = last_q;

    // Grant-stream invariants: SEL stays in range, and a stalled grant never moves.
    a_sel_range: assert property (@(posedge CLK)
        (SCLR_N && valid_q) |-> (32'(sel_q) < REQ_W));
    a_hold_stable: assert property (@(posedge CLK)
        (SCLR_N && valid_q && !READY) |=> (valid_q && (sel_q == $past(sel_q))));

endmodule

// File: tb/tb_c_rr_arbiter_select_v5_0.sv
// Bench for c_rr_arbiter_select_v5_0: directed vectors with literal expectations plus a
// per-cycle comparison against a queue-free behavioural round-robin model.
`timescale 1ns/1ps
module tb_c_rr_arbiter_select_v5_0;

    localparam int N = 8;
`ifdef RR_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce    = 1'b1;
    logic [N-1:0] req   = 8'hFF;
    logic         ready = 1'b0;
    logic         lock  = 1'b0;
    logic [2:0]   sel;
    logic         valid;
    logic [2:0]   last;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: is a grant outstanding, who holds it, and the round-robin pointer.
    bit m_valid = 1'b0;
    int m_sel   = 0;
    int m_last  = N - 1;

    c_rr_arbiter_select_v5_0 #(
        .C_REQ_WIDTH(8),
        .C_SEL_WIDTH(3),
        .C_HAS_CE   (1)
    ) dut (
        .CLK   (clk),
        .SCLR_N(rst_n),
        .CE    (ce),
        .REQ   (req),
        .READY (ready),
`ifdef RR_ARB_LOCK_EN
        .LOCK  (lock),
`endif
        .SEL   (sel),
        .VALID (valid),
        .LAST  (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Nearest set bit of mask going forward from 'from' (exclusive), wrapping around.
    function automatic int rr_next(input logic [N-1:0] mask, input int from);
        int i;
        rr_next = from;
        for (int k = N; k >= 1; k--) begin
            i = (from + k) % N;
            if (mask[i]) rr_next = i;
        end
    endfunction

    // Behavioural model stepped on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        logic [N-1:0] cand;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sel   <= 0;
            m_last  <= N - 1;
        end else if (ce) begin
            if (!m_valid) begin
                if (req != 0) begin
                    m_valid <= 1'b1;
                    m_sel   <= rr_next(req, m_last);
                end
            end else if (ready) begin
                if (!(LOCK_EN && lock && req[m_sel])) begin
                    m_last <= m_sel;
                    cand = req & ~(8'(1) << m_sel);
                    if (cand == 0) cand = req;
                    if (req != 0) m_sel <= rr_next(cand, m_sel);
                    else          m_valid <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", int'(valid), int'(m_valid));
            chk("model_last", int'(last), m_last);
            if (m_valid) chk("model_sel", int'(sel), m_sel);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string name, input int ev, input int es, input int el);
        chk({name, "_valid"}, int'(valid), ev);
        chk({name, "_last"}, int'(last), el);
        if (ev != 0) chk({name, "_sel"}, int'(sel), es);
    endtask

    initial begin
        // Reset held two cycles with everything requesting.
        rst_n = 1'b0; ce = 1'b1; req = 8'hFF; ready = 1'b0; lock = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        expect_grant("reset", 0, 0, 7);
        chk("reset_sel", int'(sel), 0);

        rst_n = 1'b1;
        step();
        expect_grant("first_grant", 1, 0, 7);

        // Full request vector streams 1..7,0 back to back.
        ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            expect_grant("stream", 1, k % 8, k - 1);
        end

        // Backpressure: grant to 2 held, survives its request dropping.
        req = 8'h24;
        step();
        expect_grant("bp_pick", 1, 2, 0);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req = 8'h20;
            step();
            expect_grant("bp_hold", 1, 2, 0);
        end
        ready = 1'b1;
        step();
        expect_grant("bp_release", 1, 5, 2);

        // Wrap-around and sparse requests, then drain to IDLE.
        req = 8'h40;
        step();
        expect_grant("to_six", 1, 6, 5);
        req = 8'h81;
        step();
        expect_grant("wrap_7", 1, 7, 6);
        step();
        expect_grant("wrap_0", 1, 0, 7);
        req = 8'h00;
        step();
        expect_grant("drain", 0, 0, 0);
        step();
        expect_grant("idle_stay", 0, 0, 0);

        // Single requester is re-granted every cycle.
        req = 8'h08;
        step();
        expect_grant("single_first", 1, 3, 0);
        step();
        expect_grant("single_again", 1, 3, 3);
        step();
        expect_grant("single_again2", 1, 3, 3);
        req = 8'h00;
        step();
        expect_grant("single_drain", 0, 0, 3);

        // Clock enable low freezes everything, in IDLE and in GRANT.
        ce = 1'b0; req = 8'h10; ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_grant("ce_idle_hold", 0, 0, 3);
        end
        ce = 1'b1;
        step();
        expect_grant("ce_resume", 1, 4, 3);
        ce = 1'b0; req = 8'hFF;
        step();
        expect_grant("ce_grant_hold", 1, 4, 3);
        step();
        expect_grant("ce_grant_hold2", 1, 4, 3);
        ce = 1'b1;
        step();
        expect_grant("ce_grant_go", 1, 5, 4);

        // Reset mid-grant, with CE low to show reset priority.
        rst_n = 1'b0; ce = 1'b0;
        step();
        expect_grant("mid_reset", 0, 0, 7);
        chk("mid_reset_sel", int'(sel), 0);
        rst_n = 1'b1; ce = 1'b1; req = 8'hFF; ready = 1'b0;
        step();
        expect_grant("post_reset", 1, 0, 7);

`ifdef RR_ARB_LOCK_EN
        // Burst lock keeps requester 1 across accepts; ignored once its request is gone.
        req = 8'h06; ready = 1'b1; lock = 1'b0;
        step();
        expect_grant("lock_pick", 1, 1, 0);
        lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_grant("lock_hold", 1, 1, 0);
        end
        lock = 1'b0;
        step();
        expect_grant("lock_release", 1, 2, 1);
        lock = 1'b1; req = 8'h02;
        step();
        expect_grant("lock_ignored", 1, 1, 2);
        lock = 1'b0;
`endif

        // Pseudo-random tail checked only by the model.
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            ce    = ($urandom_range(0, 4) != 0);
            req   = 8'($urandom) & 8'($urandom);
            ready = ($urandom_range(0, 2) != 0);
            lock  = LOCK_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
